// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: controller state encoding and default polynomials.
package lbist_pkg;

  // Response-controller states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } lbist_state_e;

  // x^16 + x^15 + x^13 + x^4 + 1, used for both the MISR and the pattern LFSR.
  localparam logic [15:0] DEFAULT_MISR_POLY = 16'hA010;
  localparam logic [15:0] DEFAULT_LFSR_POLY = 16'hA010;

endpackage : lbist_pkg

// File: rtl/misr_core.sv
// Multiple-input signature register: shift with feedback of the top bit into
// every tapped stage, XORing one full response word per enabled cycle.
module misr_core #(
  parameter int unsigned W       = 16,
  parameter logic [W-1:0] POLY   = W'(lbist_pkg::DEFAULT_MISR_POLY),
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  // One MISR step; stage 0 is always fed back, POLY[0] is ignored.
  function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] din);
    logic [W-1:0] n;
    logic         fb;
    fb   = s[W-1];
    n    = '0;
    n[0] = fb ^ din[0];
    for (int i = 1; i < int'(W); i++) begin
      n[i] = s[i-1] ^ din[i] ^ (POLY[i] & fb);
    end
    return n;
  endfunction

  // Next signature: load has priority over compaction; otherwise hold.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = load_val;
    end else if (en) begin
      sig_d = misr_step(sig_q, d);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= RST_VAL;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule : misr_core

// File: rtl/lbist_misr_ctrl.sv
// LBIST response stage: sequences a run, compacts responses into the MISR,
// counts accepted words and compares the final signature to GOLDEN.
module lbist_misr_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned  W          = 16,
  parameter logic [W-1:0] POLY       = W'(lbist_pkg::DEFAULT_MISR_POLY),
  parameter logic [W-1:0] SEED       = '0,
  parameter int unsigned  N_PATTERNS = 1000,
  parameter logic [W-1:0] GOLDEN     = '0,
  localparam int unsigned CW         = $clog2(N_PATTERNS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          resp_valid,
  input  logic [W-1:0]  resp_data,
  output logic          lfsr_reset,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] pattern_cnt
);

  // Count value of the final word of a run (0-based).
  localparam logic [CW-1:0] LAST_CNT = CW'(N_PATTERNS - 1);

  lbist_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pass_q, pass_d;
  logic          misr_load_s;
  logic          misr_en_s;
  logic [W-1:0]  sig_s;

  misr_core #(
    .W       (W),
    .POLY    (POLY),
    .RST_VAL (SEED)
  ) u_misr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (misr_load_s),
    .load_val (SEED),
    .en       (misr_en_s),
    .d        (resp_data),
    .sig      (sig_s)
  );

  // Next-state, counter, verdict and MISR control; abort overrides everything
  // and leaves signature and count untouched.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    misr_load_s = 1'b0;
    misr_en_s   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SEED;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SEED: begin
          misr_load_s = 1'b1;
          cnt_d       = '0;
          pass_d      = 1'b0;
          state_d     = ST_RUN;
        end
        ST_RUN: begin
          if (resp_valid) begin
            misr_en_s = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = ST_COMPARE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_COMPARE: begin
          pass_d  = (sig_s == GOLDEN);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_SEED;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  // Controller state, pattern counter and pass verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // Status outputs are decoded straight from the state register.
  assign lfsr_reset  = (state_q != ST_RUN);
  assign busy        = (state_q == ST_SEED) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign signature   = sig_s;
  assign pattern_cnt = cnt_q;

endmodule : lbist_misr_ctrl
